branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Branch-resolution and zero-flag controller for the 8-bit pipeline. It owns the architectural Z flag, computed as the 8-bit OR-reduction of each flag-writing ALU result, inverted. It tracks in-flight flag writers and stalls the ID stage on a flag hazard. It resolves conditional branches and drives the PC-redirect and flush signals, with one-cycle forwarding of a retiring result.

## Interface
- CNT_W, 2: width of in-flight flag-writer counter (max 3 outstanding)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- alu_result  in  8  EX-stage result
- alu_valid  in  1  alu_result valid this cycle
- flag_we  in  1  result writes Z
- issue_flag_wr  in  1  ID issues a flag-writing instruction
- stall_in  in  1  global pipeline stall; freezes Z, counter and FSM
- br_valid  in  1  branch present in ID; held until br_ack
- br_cond  in  2  00 BEQ, 01 BNE, 10 JMP, 11 reserved (never taken)
- br_target  in  8  branch target address
- zero_flag  out  1  architectural Z
- stall_out  out  1  hold IF/ID while branch waits for flag
- br_ack  out  1  one-cycle pulse: branch resolved
- take_branch  out  1  one-cycle pulse with br_ack when taken
- pc_target  out  8  redirect address, valid with take_branch
- flush_if_id  out  1  equals take_branch
- cnt_err  out  1  sticky: issue attempted at counter = 3

## Operation
- retire = alu_valid & flag_we & !stall_in; issue = issue_flag_wr & !stall_in.
- z_new = ~or_reduce(alu_result). On retire, Z <= z_new.
- Counter update:
  - issue & !retire: +1.
  - retire & !issue: −1.
  - Both or neither: unchanged.
  - issue at 3: saturate and set cnt_err.
  - retire at 0: ignored.
- flag_ready = (cnt==0) | (cnt==1 & retire & !issue).
- z_eff = retire ? z_new : Z (forwarding).
- taken = (cond==JMP) | (cond==BEQ & z_eff) | (cond==BNE & !z_eff).
- FSM states: IDLE, WAIT_FLAG, DONE.
  - IDLE: on br_valid & flag_ready, latch taken and br_target, go to DONE. On br_valid & !flag_ready, go to WAIT_FLAG.
  - WAIT_FLAG: on flag_ready, latch and go to DONE.
  - DONE: br_ack=1; take_branch=flush_if_id=latched taken; return to IDLE. br_valid is ignored in DONE; upstream drops or replaces it the following cycle.
- stall_out = (IDLE & br_valid & !flag_ready) | WAIT_FLAG. Combinational; zero in DONE.
- stall_in=1: no register changes; outputs hold their current values (DONE pulses extend).
- br_cond=11 resolves as not taken with br_ack.

## Timing
- Reset (rst_n=0 at edge) values: Z=0, cnt=0, cnt_err=0, FSM=IDLE, pc_target=0x00, br_ack=take_branch=flush_if_id=0. stall_out=0 except via the combinational term.
- Reset mid-operation: the pending branch is dropped and no ack is produced.
- No hazard: br_valid at cycle N → br_ack at N+1.
- Hazard: the last writer retires at cycle M → br_ack at M+1. The forwarded value is used, so there is no extra bubble.
- pc_target is registered; it is stable from the br_ack cycle until the next resolution.
- Z is visible on zero_flag the cycle after retire.

## Structure
- Shared package branch_pkg holds:
  - br_cond encodings BR_BEQ/BR_BNE/BR_JMP/BR_RSV.
  - FSM state enum (IDLE, WAIT_FLAG, DONE).
  - CNT_MAX=3.
- One sub-module, or_reduce8: an 8-bit OR reduction, instantiated on alu_result.
- All sequential logic in a single clocked process with synchronous reset.

## Test plan
- Reset: rst_n=0 two cycles → all outputs 0, zero_flag=0. Retire alu_result=0x00 → zero_flag=1 next cycle. Retire 0x80 → zero_flag=0.
- No hazard, BEQ: Z=1, cnt=0, br_valid with target 0x3C at N → br_ack, take_branch, flush_if_id at N+1, pc_target=0x3C, stall_out=0 throughout.
- Forwarding, BNE: issue one writer; next cycle br_valid BNE target 0x10 and retire result 0x05 in the same cycle → no stall, br_ack + take_branch next cycle.
- Two-deep hazard, BEQ:
  - Issue two writers; br_valid BEQ → stall_out=1.
  - Retire 0x00, then hold 2 cycles, then retire 0x01 → stall holds until the second retire.
  - br_ack the cycle after, take_branch=0.
- Simultaneous and saturation:
  - issue & retire in the same cycle → cnt unchanged.
  - Four issues with no retire → cnt stays 3, cnt_err=1 and sticky until reset.
- stall_in and reset mid-op:
  - stall_in=1 during WAIT_FLAG with retire → Z and cnt unchanged.
  - rst_n=0 while in WAIT_FLAG → next cycle IDLE, no br_ack, cnt=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the branch-resolution controller: branch conditions,
// FSM states, counter limit and the taken/not-taken decision.
package branch_pkg;

  localparam int CNT_MAX = 3;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_JMP = 2'b10,
    BR_RSV = 2'b11
  } br_cond_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_FLAG = 2'b01,
    DONE      = 2'b10
  } state_e;

  // Reserved encoding resolves as not taken so a stray opcode never redirects.
  function automatic logic resolve_taken(input logic [1:0] cond, input logic z);
    logic taken;
    taken = 1'b0;
    case (cond)
      BR_BEQ:  taken = z;
      BR_BNE:  taken = ~z;
      BR_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/or_reduce8.sv
// 8-bit OR reduction used to derive the zero flag from an ALU result.
module or_reduce8 (
  input  logic [7:0] data,
  output logic       any_set
);

  assign any_set = |data;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Owns the architectural Z flag, counts in-flight flag writers and resolves
// conditional branches, forwarding a retiring result to avoid an extra bubble.
//
// state     | meaning
// IDLE      | no branch pending; resolves at once when the flag is ready
// WAIT_FLAG | branch held in ID, waiting for the last flag writer to retire
// DONE      | one-cycle ack/redirect pulse (extended while stall_in is high)
import branch_pkg::*;

module branch_resolve_ctrl #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] alu_result,
  input  logic       alu_valid,
  input  logic       flag_we,
  input  logic       issue_flag_wr,
  input  logic       stall_in,
  input  logic       br_valid,
  input  logic [1:0] br_cond,
  input  logic [7:0] br_target,
  output logic       zero_flag,
  output logic       stall_out,
  output logic       br_ack,
  output logic       take_branch,
  output logic [7:0] pc_target,
  output logic       flush_if_id,
  output logic       cnt_err
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_err_q, cnt_err_d;
  logic             z_q;
  logic             taken_q;
  logic [7:0]       pc_target_q;

  logic result_nz;
  logic z_new, z_eff;
  logic retire, issue;
  logic flag_ready;
  logic taken;
  logic latch;

  or_reduce8 u_or_reduce8 (
    .data    (alu_result),
    .any_set (result_nz)
  );

  assign retire = alu_valid & flag_we & ~stall_in;
  assign issue  = issue_flag_wr & ~stall_in;
  assign z_new  = ~result_nz;
  assign z_eff  = retire ? z_new : z_q;
  assign taken  = resolve_taken(br_cond, z_eff);

  // A lone retire of the last outstanding writer makes the flag usable in the
  // same cycle through z_eff.
  assign flag_ready = (cnt_q == '0) | ((cnt_q == CNT_ONE) & retire & ~issue);

  always_comb begin
    cnt_d     = cnt_q;
    cnt_err_d = cnt_err_q;
    if (issue && !retire) begin
      if (cnt_q == CNT_TOP) cnt_err_d = 1'b1;
      else                  cnt_d     = cnt_q + CNT_ONE;
    end else if (retire && !issue && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    stall_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (br_valid) begin
          if (flag_ready) begin
            latch   = 1'b1;
            state_d = DONE;
          end else begin
            stall_out = 1'b1;
            state_d   = WAIT_FLAG;
          end
        end
      end
      WAIT_FLAG: begin
        stall_out = 1'b1;
        if (flag_ready) begin
          latch   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cnt_err_q   <= 1'b0;
      z_q         <= 1'b0;
      taken_q     <= 1'b0;
      pc_target_q <= 8'h00;
    end else if (!stall_in) begin
      if (retire) z_q <= z_new;
      cnt_q     <= cnt_d;
      cnt_err_q <= cnt_err_d;
      state_q   <= state_d;
      if (latch) begin
        taken_q     <= taken;
        pc_target_q <= br_target;
      end
    end
  end

  assign zero_flag   = z_q;
  assign br_ack      = (state_q == DONE);
  assign take_branch = br_ack & taken_q;
  assign flush_if_id = take_branch;
  assign pc_target   = pc_target_q;
  assign cnt_err     = cnt_err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scenario bench for branch_resolve_ctrl: expected branch outcomes are queued
// when a branch is presented and compared when br_ack appears.
module tb_branch_resolve_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] alu_result;
  logic       alu_valid;
  logic       flag_we;
  logic       issue_flag_wr;
  logic       stall_in;
  logic       br_valid;
  logic [1:0] br_cond;
  logic [7:0] br_target;
  logic       zero_flag;
  logic       stall_out;
  logic       br_ack;
  logic       take_branch;
  logic [7:0] pc_target;
  logic       flush_if_id;
  logic       cnt_err;

  typedef struct packed {
    logic       taken;
    logic [7:0] target;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic z_model;
  int   n_checks = 0;
  int   n_pass   = 0;

  branch_resolve_ctrl #(.CNT_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_result    (alu_result),
    .alu_valid     (alu_valid),
    .flag_we       (flag_we),
    .issue_flag_wr (issue_flag_wr),
    .stall_in      (stall_in),
    .br_valid      (br_valid),
    .br_cond       (br_cond),
    .br_target     (br_target),
    .zero_flag     (zero_flag),
    .stall_out     (stall_out),
    .br_ack        (br_ack),
    .take_branch   (take_branch),
    .pc_target     (pc_target),
    .flush_if_id   (flush_if_id),
    .cnt_err       (cnt_err)
  );

  always #5 clk = ~clk;

  function automatic logic model_taken(input logic [1:0] c, input logic z);
    return (c == 2'b10) | ((c == 2'b00) & z) | ((c == 2'b01) & ~z);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    alu_valid = 1'b0; flag_we = 1'b0; alu_result = 8'h00;
    issue_flag_wr = 1'b0; stall_in = 1'b0;
    br_valid = 1'b0; br_cond = 2'b00; br_target = 8'h00;
  endtask

  task automatic retire_set(input logic [7:0] r);
    alu_valid = 1'b1; flag_we = 1'b1; alu_result = r;
  endtask

  task automatic push_exp(input logic [1:0] c, input logic z, input logic [7:0] t);
    exp_t x;
    x.taken = model_taken(c, z);
    x.target = t;
    sb.push_back(x);
  endtask

  task automatic pop_exp();
    if (sb.size() != 0) e = sb.pop_front();
    else e = '0;
  endtask

  task automatic test_reset();
    clr_in(); rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (zero_flag !== 1'b0) $display("FAIL rst_z: got %b want 0", zero_flag); else n_pass++;
    n_checks++; if (br_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", br_ack); else n_pass++;
    n_checks++; if (take_branch !== 1'b0) $display("FAIL rst_take: got %b want 0", take_branch); else n_pass++;
    n_checks++; if (flush_if_id !== 1'b0) $display("FAIL rst_flush: got %b want 0", flush_if_id); else n_pass++;
    n_checks++; if (pc_target !== 8'h00) $display("FAIL rst_pc: got %h want 00", pc_target); else n_pass++;
    n_checks++; if (stall_out !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall_out); else n_pass++;
    n_checks++; if (cnt_err !== 1'b0) $display("FAIL rst_err: got %b want 0", cnt_err); else n_pass++;
    rst_n = 1'b1; z_model = 1'b0; sb.delete();
    retire_set(8'h00); tick(); clr_in(); z_model = 1'b1;
    n_checks++; if (zero_flag !== z_model) $display("FAIL z_00: got %b want %b", zero_flag, z_model); else n_pass++;
    retire_set(8'h80); tick(); clr_in(); z_model = 1'b0;
    n_checks++; if (zero_flag !== z_model) $display("FAIL z_80: got %b want %b", zero_flag, z_model); else n_pass++;
  endtask

  task automatic test_no_hazard_beq();
    retire_set(8'h00); tick(); clr_in(); z_model = 1'b1;
    br_valid = 1'b1; br_cond = 2'b00; br_target = 8'h3C;
    push_exp(2'b00, z_model, 8'h3C);
    #1;
    n_checks++; if (stall_out !== 1'b0) $display("FAIL nh_stall0: got %b want 0", stall_out); else n_pass++;
    n_checks++; if (br_ack !== 1'b0) $display("FAIL nh_early_ack: got %b want 0", br_ack); else n_pass++;
    tick(); br_valid = 1'b0; #1;
    pop_exp();
    n_checks++; if (br_ack !== 1'b1) $display("FAIL nh_ack: got %b want 1", br_ack); else n_pass++;
    n_checks++; if (take_branch !== e.taken) $display("FAIL nh_take: got %b want %b", take_branch, e.taken); else n_pass++;
    n_checks++; if (flush_if_id !== e.taken) $display("FAIL nh_flush: got %b want %b", flush_if_id, e.taken); else n_pass++;
    n_checks++; if (pc_target !== e.target) $display("FAIL nh_pc: got %h want %h", pc_target, e.target); else n_pass++;
    n_checks++; if (stall_out !== 1'b0) $display("FAIL nh_stall1: got %b want 0", stall_out); else n_pass++;
    tick();
    n_checks++; if (br_ack !== 1'b0) $display("FAIL nh_ack_pulse: got %b want 0", br_ack); else n_pass++;
    n_checks++; if (pc_target !== 8'h3C) $display("FAIL nh_pc_hold: got %h want 3c", pc_target); else n_pass++;
  endtask

  task automatic test_forward_bne();
    issue_flag_wr = 1'b1; tick(); clr_in();
    br_valid = 1'b1; br_cond = 2'b01; br_target = 8'h10;
    retire_set(8'h05); z_model = 1'b0;
    push_exp(2'b01, z_model, 8'h10);
    #1;
    n_checks++; if (stall_out !== 1'b0) $display("FAIL fwd_stall: got %b want 0", stall_out); else n_pass++;
    tick(); clr_in(); pop_exp();
    n_checks++; if (br_ack !== 1'b1) $display("FAIL fwd_ack: got %b want 1", br_ack); else n_pass++;
    n_checks++; if (take_branch !== e.taken) $display("FAIL fwd_take: got %b want %b", take_branch, e.taken); else n_pass++;
    n_checks++; if (pc_target !== e.target) $display("FAIL fwd_pc: got %h want %h", pc_target, e.target); else n_pass++;
    n_checks++; if (zero_flag !== z_model) $display("FAIL fwd_z: got %b want %b", zero_flag, z_model); else n_pass++;
    tick();
  endtask

  task automatic test_two_deep_beq();
    issue_flag_wr = 1'b1; tick(); tick(); clr_in();
    br_valid = 1'b1; br_cond = 2'b00; br_target = 8'h55; #1;
    n_checks++; if (stall_out !== 1'b1) $display("FAIL td_stall_idle: got %b want 1", stall_out); else n_pass++;
    tick();
    retire_set(8'h00); #1;
    n_checks++; if (stall_out !== 1'b1) $display("FAIL td_stall_r1: got %b want 1", stall_out); else n_pass++;
    tick(); alu_valid = 1'b0; flag_we = 1'b0; z_model = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (stall_out !== 1'b1) $display("FAIL td_stall_hold%0d: got %b want 1", i, stall_out); else n_pass++;
      n_checks++; if (br_ack !== 1'b0) $display("FAIL td_ack_hold%0d: got %b want 0", i, br_ack); else n_pass++;
      tick();
    end
    retire_set(8'h01); z_model = 1'b0;
    push_exp(2'b00, z_model, 8'h55);
    #1;
    n_checks++; if (stall_out !== 1'b1) $display("FAIL td_stall_r2: got %b want 1", stall_out); else n_pass++;
    tick(); alu_valid = 1'b0; flag_we = 1'b0; #1;
    pop_exp();
    n_checks++; if (br_ack !== 1'b1) $display("FAIL td_ack: got %b want 1", br_ack); else n_pass++;
    n_checks++; if (take_branch !== e.taken) $display("FAIL td_take: got %b want %b", take_branch, e.taken); else n_pass++;
    n_checks++; if (flush_if_id !== e.taken) $display("FAIL td_flush: got %b want %b", flush_if_id, e.taken); else n_pass++;
    n_checks++; if (pc_target !== e.target) $display("FAIL td_pc: got %h want %h", pc_target, e.target); else n_pass++;
    n_checks++; if (stall_out !== 1'b0) $display("FAIL td_stall_done: got %b want 0", stall_out); else n_pass++;
    n_checks++; if (zero_flag !== z_model) $display("FAIL td_z: got %b want %b", zero_flag, z_model); else n_pass++;
    clr_in(); tick();
  endtask

  task automatic test_simultaneous_sat();
    issue_flag_wr = 1'b1; tick(); clr_in();
    issue_flag_wr = 1'b1; retire_set(8'h01); tick(); clr_in(); z_model = 1'b0;
    br_valid = 1'b1; br_cond = 2'b10; br_target = 8'hA0; #1;
    n_checks++; if (stall_out !== 1'b1) $display("FAIL sim_cnt_held: got %b want 1", stall_out); else n_pass++;
    tick();
    retire_set(8'hFF); z_model = 1'b0;
    push_exp(2'b10, z_model, 8'hA0);
    tick(); clr_in(); pop_exp();
    n_checks++; if (br_ack !== 1'b1) $display("FAIL sim_ack: got %b want 1", br_ack); else n_pass++;
    n_checks++; if (take_branch !== e.taken) $display("FAIL sim_take: got %b want %b", take_branch, e.taken); else n_pass++;
    n_checks++; if (pc_target !== e.target) $display("FAIL sim_pc: got %h want %h", pc_target, e.target); else n_pass++;
    tick();
    issue_flag_wr = 1'b1; tick(); tick(); tick();
    n_checks++; if (cnt_err !== 1'b0) $display("FAIL sat_err_early: got %b want 0", cnt_err); else n_pass++;
    tick(); clr_in();
    n_checks++; if (cnt_err !== 1'b1) $display("FAIL sat_err: got %b want 1", cnt_err); else n_pass++;
    br_valid = 1'b1; br_cond = 2'b00; br_target = 8'h77; #1;
    n_checks++; if (stall_out !== 1'b1) $display("FAIL sat_stall: got %b want 1", stall_out); else n_pass++;
    tick();
    retire_set(8'h02); tick();
    n_checks++; if (br_ack !== 1'b0) $display("FAIL sat_ack_r1: got %b want 0", br_ack); else n_pass++;
    retire_set(8'h04); tick();
    n_checks++; if (br_ack !== 1'b0) $display("FAIL sat_ack_r2: got %b want 0", br_ack); else n_pass++;
    retire_set(8'h00); z_model = 1'b1;
    push_exp(2'b00, z_model, 8'h77);
    tick(); clr_in(); pop_exp();
    n_checks++; if (br_ack !== 1'b1) $display("FAIL sat_ack: got %b want 1", br_ack); else n_pass++;
    n_checks++; if (take_branch !== e.taken) $display("FAIL sat_take: got %b want %b", take_branch, e.taken); else n_pass++;
    n_checks++; if (pc_target !== e.target) $display("FAIL sat_pc: got %h want %h", pc_target, e.target); else n_pass++;
    tick();
    n_checks++; if (cnt_err !== 1'b1) $display("FAIL sat_sticky: got %b want 1", cnt_err); else n_pass++;
  endtask

  task automatic test_stall_in();
    issue_flag_wr = 1'b1; tick(); clr_in();
    br_valid = 1'b1; br_cond = 2'b01; br_target = 8'h22;
    tick();
    stall_in = 1'b1; retire_set(8'h09); #1;
    n_checks++; if (stall_out !== 1'b1) $display("FAIL stl_stall: got %b want 1", stall_out); else n_pass++;
    tick(); stall_in = 1'b0; alu_valid = 1'b0; flag_we = 1'b0;
    n_checks++; if (zero_flag !== z_model) $display("FAIL stl_z_frozen: got %b want %b", zero_flag, z_model); else n_pass++;
    n_checks++; if (br_ack !== 1'b0) $display("FAIL stl_ack0: got %b want 0", br_ack); else n_pass++;
    #1;
    n_checks++; if (stall_out !== 1'b1) $display("FAIL stl_cnt_frozen: got %b want 1", stall_out); else n_pass++;
    tick();
    n_checks++; if (br_ack !== 1'b0) $display("FAIL stl_ack1: got %b want 0", br_ack); else n_pass++;
    retire_set(8'h09); z_model = 1'b0;
    push_exp(2'b01, z_model, 8'h22);
    tick(); clr_in(); pop_exp();
    n_checks++; if (br_ack !== 1'b1) $display("FAIL stl_ack: got %b want 1", br_ack); else n_pass++;
    n_checks++; if (take_branch !== e.taken) $display("FAIL stl_take: got %b want %b", take_branch, e.taken); else n_pass++;
    n_checks++; if (pc_target !== e.target) $display("FAIL stl_pc: got %h want %h", pc_target, e.target); else n_pass++;
    stall_in = 1'b1; tick();
    n_checks++; if (br_ack !== 1'b1) $display("FAIL stl_done_ext: got %b want 1", br_ack); else n_pass++;
    n_checks++; if (take_branch !== e.taken) $display("FAIL stl_take_ext: got %b want %b", take_branch, e.taken); else n_pass++;
    stall_in = 1'b0; tick();
    n_checks++; if (br_ack !== 1'b0) $display("FAIL stl_done_end: got %b want 0", br_ack); else n_pass++;
  endtask

  task automatic test_reset_midop();
    issue_flag_wr = 1'b1; tick(); clr_in();
    br_valid = 1'b1; br_cond = 2'b00; br_target = 8'h99;
    tick();
    br_valid = 1'b0; rst_n = 1'b0;
    tick(); rst_n = 1'b1; z_model = 1'b0;
    n_checks++; if (br_ack !== 1'b0) $display("FAIL rm_ack: got %b want 0", br_ack); else n_pass++;
    n_checks++; if (cnt_err !== 1'b0) $display("FAIL rm_err: got %b want 0", cnt_err); else n_pass++;
    n_checks++; if (zero_flag !== 1'b0) $display("FAIL rm_z: got %b want 0", zero_flag); else n_pass++;
    n_checks++; if (pc_target !== 8'h00) $display("FAIL rm_pc: got %h want 00", pc_target); else n_pass++;
    n_checks++; if (stall_out !== 1'b0) $display("FAIL rm_stall: got %b want 0", stall_out); else n_pass++;
    tick();
    n_checks++; if (br_ack !== 1'b0) $display("FAIL rm_late_ack: got %b want 0", br_ack); else n_pass++;
    br_valid = 1'b1; br_cond = 2'b10; br_target = 8'h44;
    push_exp(2'b10, z_model, 8'h44);
    #1;
    n_checks++; if (stall_out !== 1'b0) $display("FAIL rm_cnt0: got %b want 0", stall_out); else n_pass++;
    tick(); clr_in(); pop_exp();
    n_checks++; if (br_ack !== 1'b1) $display("FAIL rm_ack2: got %b want 1", br_ack); else n_pass++;
    n_checks++; if (pc_target !== e.target) $display("FAIL rm_pc2: got %h want %h", pc_target, e.target); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] res, tgt;
    logic [1:0] cnd;
    for (int i = 0; i < 8; i++) begin
      res = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      cnd = (i == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      tgt = 8'($urandom_range(0, 255));
      retire_set(res); z_model = (res == 8'h00);
      br_valid = 1'b1; br_cond = cnd; br_target = tgt;
      push_exp(cnd, z_model, tgt);
      #1;
      n_checks++; if (stall_out !== 1'b0) $display("FAIL b2b%0d_stall: got %b want 0", i, stall_out); else n_pass++;
      tick(); clr_in(); pop_exp();
      n_checks++; if (br_ack !== 1'b1) $display("FAIL b2b%0d_ack: got %b want 1", i, br_ack); else n_pass++;
      n_checks++; if (take_branch !== e.taken) $display("FAIL b2b%0d_take: cond=%b got %b want %b", i, cnd, take_branch, e.taken); else n_pass++;
      n_checks++; if (flush_if_id !== e.taken) $display("FAIL b2b%0d_flush: got %b want %b", i, flush_if_id, e.taken); else n_pass++;
      n_checks++; if (pc_target !== e.target) $display("FAIL b2b%0d_pc: got %h want %h", i, pc_target, e.target); else n_pass++;
      n_checks++; if (zero_flag !== z_model) $display("FAIL b2b%0d_z: got %b want %b", i, zero_flag, z_model); else n_pass++;
      tick();
    end
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    z_model = 1'b0;
    test_reset();
    test_no_hazard_beq();
    test_forward_bne();
    test_two_deep_beq();
    test_simultaneous_sat();
    test_stall_in();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
